// File: rtl/reg_file_pkg.sv
// Shared helpers for the multi-port register file: lane arithmetic, the legal-parameter
// predicate, and default-width type templates.
package reg_file_pkg;

   localparam int DEF_WORD_W = 32;
   localparam int DEF_BYTE_W = 8;

   typedef logic [DEF_WORD_W-1:0]              word_t;
   typedef logic [DEF_WORD_W/DEF_BYTE_W-1:0]   bytes_en_t;

   function automatic int num_bytes(input int word_w, input int byte_w);
      return word_w / byte_w;
   endfunction

   function automatic bit params_legal(input int word_w, input int byte_w,
                                       input int read_latency, input int num_wports);
      return (byte_w > 0) && (word_w % byte_w == 0) && (read_latency >= 0) &&
             (read_latency <= 1) && (num_wports >= 1);
   endfunction

endpackage

// File: rtl/reg_file_wmerge.sv
// Next-value merge for a single word: applies every write port's byte lanes in port order
// so the highest-numbered port wins a shared lane, and reports any lane overlap.
module reg_file_wmerge
   import reg_file_pkg::*;
#(
   parameter int WORD_W      = 32,
   parameter int BYTE_W      = 8,
   parameter int SEL_W       = 5,
   parameter int NUM_WPORTS  = 1,
   parameter int WORD_IDX    = 0,
   parameter bit DROP_WRITES = 1'b0
) (
   input  logic [WORD_W-1:0]                          cur,
   input  logic [NUM_WPORTS-1:0]                      wen,
   input  logic [NUM_WPORTS*SEL_W-1:0]                wsel,
   input  logic [NUM_WPORTS*num_bytes(WORD_W, BYTE_W)-1:0] wbe,
   input  logic [NUM_WPORTS*WORD_W-1:0]               wdata,
   output logic [WORD_W-1:0]                          nxt,
   output logic                                       overlap
);

   localparam int NB = num_bytes(WORD_W, BYTE_W);

   logic [WORD_W-1:0] merged;
   logic [NB-1:0]     lane_hit;

   always_comb begin
      merged   = cur;
      lane_hit = '0;
      overlap  = 1'b0;
      for (int p = 0; p < NUM_WPORTS; p++) begin
         if (wen[p] && (wsel[p*SEL_W +: SEL_W] == SEL_W'(WORD_IDX))) begin
            for (int b = 0; b < NB; b++) begin
               if (wbe[p*NB + b]) begin
                  if (lane_hit[b]) overlap = 1'b1;
                  lane_hit[b] = 1'b1;
                  merged[b*BYTE_W +: BYTE_W] = wdata[p*WORD_W + b*BYTE_W +: BYTE_W];
               end
            end
         end
      end
   end

   // A hardwired-zero word still reports overlap but never takes a new value.
   assign nxt = DROP_WRITES ? '0 : merged;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port byte-enabled register file with optional zero word, write-to-read bypass
// and optional registered read ports.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int WORD_W       = 32,
   parameter int BYTE_W       = 8,
   parameter int NUM_WORDS    = 32,
   parameter int SEL_W        = $clog2(NUM_WORDS),
   parameter int NUM_RPORTS   = 2,
   parameter int NUM_WPORTS   = 1,
   parameter bit ZERO_REG     = 1'b1,
   parameter bit BYPASS       = 1'b1,
   parameter int READ_LATENCY = 0,
   parameter logic [WORD_W*NUM_WORDS-1:0] RESET_WORDS = '0
) (
   input  logic                                           clk,
   input  logic                                           reset,
   input  logic [NUM_WPORTS-1:0]                          wen,
   input  logic [NUM_WPORTS*SEL_W-1:0]                    wsel,
   input  logic [NUM_WPORTS*num_bytes(WORD_W, BYTE_W)-1:0] wbe,
   input  logic [NUM_WPORTS*WORD_W-1:0]                   wdata,
   input  logic [NUM_RPORTS*SEL_W-1:0]                    rsel,
   output logic [NUM_RPORTS*WORD_W-1:0]                   rdata,
   output logic                                           wr_conflict,
   output logic                                           wr_oob
);

   localparam int  SEL_SPAN = 1 << SEL_W;
   localparam bit  USE_NEXT = (READ_LATENCY == 1) || BYPASS;

   if (!params_legal(WORD_W, BYTE_W, READ_LATENCY, NUM_WPORTS)) begin : g_param_check
      $error("reg_file_mp: illegal parameter combination");
   end

   function automatic logic [SEL_SPAN-1:0] valid_mask();
      logic [SEL_SPAN-1:0] m;
      m = '0;
      for (int i = 0; i < SEL_SPAN; i++) m[i] = (i < NUM_WORDS);
      return m;
   endfunction

   function automatic logic [WORD_W-1:0] reset_word(input int w);
      if (ZERO_REG && (w == 0)) return '0;
      return RESET_WORDS[w*WORD_W +: WORD_W];
   endfunction

   localparam logic [SEL_SPAN-1:0] SEL_VALID = valid_mask();

   logic [WORD_W-1:0]     word_q [NUM_WORDS];
   logic [WORD_W-1:0]     word_d [NUM_WORDS];
   logic [WORD_W-1:0]     rd_src [SEL_SPAN];
   logic [NUM_WORDS-1:0]  overlap;
   logic [NUM_WPORTS-1:0] wen_eff;
   logic                  wr_conflict_q, wr_conflict_d;
   logic                  wr_oob_q, wr_oob_d;

   // While reset is high nothing may commit, so the bypass path must not show pending data either.
   assign wen_eff = reset ? '0 : wen;

   for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
      reg_file_wmerge #(
         .WORD_W      (WORD_W),
         .BYTE_W      (BYTE_W),
         .SEL_W       (SEL_W),
         .NUM_WPORTS  (NUM_WPORTS),
         .WORD_IDX    (w),
         .DROP_WRITES (ZERO_REG && (w == 0))
      ) u_wmerge (
         .cur     (word_q[w]),
         .wen     (wen_eff),
         .wsel    (wsel),
         .wbe     (wbe),
         .wdata   (wdata),
         .nxt     (word_d[w]),
         .overlap (overlap[w])
      );
   end

   always_comb begin
      wr_conflict_d = |overlap;
      wr_oob_d      = 1'b0;
      for (int p = 0; p < NUM_WPORTS; p++) begin
         if (wen_eff[p] && !SEL_VALID[wsel[p*SEL_W +: SEL_W]]) wr_oob_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int w = 0; w < NUM_WORDS; w++) word_q[w] <= reset_word(w);
         wr_conflict_q <= 1'b0;
         wr_oob_q      <= 1'b0;
      end else begin
         for (int w = 0; w < NUM_WORDS; w++) word_q[w] <= word_d[w];
         wr_conflict_q <= wr_conflict_d;
         wr_oob_q      <= wr_oob_d;
      end
   end

   assign wr_conflict = wr_conflict_q;
   assign wr_oob      = wr_oob_q;

   // Selects past the last word land on zero-tied entries, so no range compare is needed.
   for (genvar i = 0; i < SEL_SPAN; i++) begin : g_rd_src
      if (i < NUM_WORDS) begin : g_word_src
         assign rd_src[i] = USE_NEXT ? word_d[i] : word_q[i];
      end else begin : g_zero_src
         assign rd_src[i] = '0;
      end
   end

   logic [NUM_RPORTS*WORD_W-1:0] rdata_d;

   always_comb begin
      rdata_d = '0;
      for (int r = 0; r < NUM_RPORTS; r++) begin
         rdata_d[r*WORD_W +: WORD_W] = rd_src[rsel[r*SEL_W +: SEL_W]];
      end
   end

   if (READ_LATENCY == 0) begin : g_rd_comb
      assign rdata = rdata_d;
   end else begin : g_rd_reg
      logic [NUM_RPORTS*WORD_W-1:0] rdata_q;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) rdata_q <= '0;
         else       rdata_q <= rdata_d;
      end

      assign rdata = rdata_q;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: three instances (bypass comb, plain comb, registered read)
// share one stimulus stream; expected values are hand-computed per vector.
module tb_reg_file_mp;

   localparam int NW = 24;
   localparam logic [32*NW-1:0] RW = (32*NW)'(32'hDEAD_BEEF) << (5*32);

   logic        clk;
   logic        reset;
   logic [1:0]  wen;
   logic [9:0]  wsel;
   logic [7:0]  wbe;
   logic [63:0] wdata;
   logic [9:0]  rsel;
   logic [63:0] ra, rb, rc;
   logic        conf_a, oob_a, conf_b, oob_b, conf_c, oob_c;

   int n_tests = 0;
   int n_fail  = 0;

   reg_file_mp #(.NUM_WORDS(NW), .NUM_WPORTS(2), .BYPASS(1'b1), .READ_LATENCY(0),
                 .RESET_WORDS(RW)) u_a (
      .clk(clk), .reset(reset), .wen(wen), .wsel(wsel), .wbe(wbe), .wdata(wdata),
      .rsel(rsel), .rdata(ra), .wr_conflict(conf_a), .wr_oob(oob_a));

   reg_file_mp #(.NUM_WORDS(NW), .NUM_WPORTS(2), .BYPASS(1'b0), .READ_LATENCY(0),
                 .RESET_WORDS(RW)) u_b (
      .clk(clk), .reset(reset), .wen(wen), .wsel(wsel), .wbe(wbe), .wdata(wdata),
      .rsel(rsel), .rdata(rb), .wr_conflict(conf_b), .wr_oob(oob_b));

   reg_file_mp #(.NUM_WORDS(NW), .NUM_WPORTS(2), .BYPASS(1'b1), .READ_LATENCY(1),
                 .RESET_WORDS(RW)) u_c (
      .clk(clk), .reset(reset), .wen(wen), .wsel(wsel), .wbe(wbe), .wdata(wdata),
      .rsel(rsel), .rdata(rc), .wr_conflict(conf_c), .wr_oob(oob_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  wen;
      logic [4:0]  ws0, ws1;
      logic [3:0]  be0, be1;
      logic [31:0] d0, d1;
      logic [4:0]  rs0, rs1;
      logic [31:0] a0, a1, b1, c1;
      logic        conf, oob;
   } vec_t;

   vec_t vt [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      wen   = v.wen;
      wsel  = {v.ws1, v.ws0};
      wbe   = {v.be1, v.be0};
      wdata = {v.d1, v.d0};
      rsel  = {v.rs1, v.rs0};
   endtask

   initial begin
      //         wen    ws0   ws1   be0   be1   d0            d1            rs0   rs1   a0            a1            b1            c1            cf    oob
      vt[0]  = '{2'b01, 5'd3, 5'd0, 4'hF, 4'h0, 32'h11223344, 32'h0,        5'd3, 5'd5, 32'h11223344, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
      vt[1]  = '{2'b01, 5'd3, 5'd0, 4'h5, 4'h0, 32'hAABBCCDD, 32'h0,        5'd3, 5'd3, 32'h11BB33DD, 32'h11BB33DD, 32'h11223344, 32'hDEADBEEF, 1'b0, 1'b0};
      vt[2]  = '{2'b00, 5'd0, 5'd0, 4'h0, 4'h0, 32'h0,        32'h0,        5'd3, 5'd3, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 1'b0, 1'b0};
      vt[3]  = '{2'b11, 5'd7, 5'd7, 4'hF, 4'hF, 32'h1,        32'h2,        5'd7, 5'd7, 32'h2,        32'h2,        32'h0,        32'h11BB33DD, 1'b0, 1'b0};
      vt[4]  = '{2'b11, 5'd8, 5'd8, 4'h3, 4'hC, 32'h12345678, 32'h9ABCDEF0, 5'd7, 5'd8, 32'h2,        32'h9ABC5678, 32'h0,        32'h2,        1'b1, 1'b0};
      vt[5]  = '{2'b01, 5'd9, 5'd0, 4'hF, 4'h0, 32'h55,       32'h0,        5'd8, 5'd9, 32'h9ABC5678, 32'h55,       32'h0,        32'h9ABC5678, 1'b0, 1'b0};
      vt[6]  = '{2'b00, 5'd0, 5'd0, 4'h0, 4'h0, 32'h0,        32'h0,        5'd0, 5'd9, 32'h0,        32'h55,       32'h55,       32'h55,       1'b0, 1'b0};
      vt[7]  = '{2'b01, 5'd0, 5'd0, 4'hF, 4'h0, 32'hFFFF,     32'h0,        5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        32'h55,       1'b0, 1'b0};
      vt[8]  = '{2'b10, 5'd0, 5'd30,4'h0, 4'hF, 32'h0,        32'hFFFFFFFF, 5'd30,5'd0, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 1'b0};
      vt[9]  = '{2'b00, 5'd0, 5'd0, 4'h0, 4'h0, 32'h0,        32'h0,        5'd30,5'd3, 32'h0,        32'h11BB33DD, 32'h11BB33DD, 32'h0,        1'b0, 1'b1};
      vt[10] = '{2'b11, 5'd3, 5'd3, 4'hF, 4'h6, 32'h01020304, 32'hA0B0C0D0, 5'd3, 5'd3, 32'h01B0C004, 32'h01B0C004, 32'h11BB33DD, 32'h11BB33DD, 1'b0, 1'b0};
      vt[11] = '{2'b01, 5'd3, 5'd0, 4'h0, 4'h0, 32'hFFFFFFFF, 32'h0,        5'd3, 5'd7, 32'h01B0C004, 32'h2,        32'h2,        32'h01B0C004, 1'b1, 1'b0};
      vt[12] = '{2'b00, 5'd0, 5'd0, 4'h0, 4'h0, 32'h0,        32'h0,        5'd3, 5'd3, 32'h01B0C004, 32'h01B0C004, 32'h01B0C004, 32'h2,        1'b0, 1'b0};
      vt[13] = '{2'b11, 5'd31,5'd31,4'hF, 4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'h01B0C004, 1'b0, 1'b0};
      vt[14] = '{2'b00, 5'd0, 5'd0, 4'h0, 4'h0, 32'h0,        32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1};

      reset = 1'b1;
      wen   = '0;
      wsel  = '0;
      wbe   = '0;
      wdata = '0;
      rsel  = {5'd5, 5'd5};
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst a0 word5", ra[31:0], 32'hDEADBEEF);
      check("rst b1 word5", rb[63:32], 32'hDEADBEEF);
      check("rst c0 zero", rc[31:0], 32'h0);
      check("rst c1 zero", rc[63:32], 32'h0);
      check("rst conflict", {31'b0, conf_a}, 32'h0);
      check("rst oob", {31'b0, oob_a}, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         drive(vt[i]);
         #1;
         check($sformatf("v%0d a0", i), ra[31:0], vt[i].a0);
         check($sformatf("v%0d a1", i), ra[63:32], vt[i].a1);
         check($sformatf("v%0d b1", i), rb[63:32], vt[i].b1);
         check($sformatf("v%0d c1", i), rc[63:32], vt[i].c1);
         check($sformatf("v%0d conflict", i), {31'b0, conf_a}, {31'b0, vt[i].conf});
         check($sformatf("v%0d oob", i), {31'b0, oob_a}, {31'b0, vt[i].oob});
      end

      // Reset asserted between edges while a conflicting write is pending.
      @(negedge clk);
      wen   = 2'b01;
      wsel  = {5'd0, 5'd5};
      wbe   = 8'h0F;
      wdata = {32'h0, 32'h12345678};
      rsel  = {5'd10, 5'd5};
      @(negedge clk);
      wen   = 2'b11;
      wsel  = {5'd10, 5'd10};
      wbe   = 8'hFF;
      wdata = {32'h11111111, 32'hCAFEF00D};
      #1;
      check("mid pre a0 word5", ra[31:0], 32'h12345678);
      check("mid pre a1 bypass", ra[63:32], 32'h11111111);
      #1;
      reset = 1'b1;
      #1;
      check("mid rst a0", ra[31:0], 32'hDEADBEEF);
      check("mid rst a1", ra[63:32], 32'h0);
      check("mid rst b1", rb[63:32], 32'h0);
      check("mid rst c0", rc[31:0], 32'h0);
      check("mid rst c1", rc[63:32], 32'h0);
      @(negedge clk);
      reset = 1'b0;
      wen   = 2'b00;
      #1;
      check("post rst a0", ra[31:0], 32'hDEADBEEF);
      check("post rst a1", ra[63:32], 32'h0);
      check("post rst conflict", {31'b0, conf_a}, 32'h0);
      @(posedge clk);
      #1;
      check("post edge c0", rc[31:0], 32'hDEADBEEF);
      check("post edge c1", rc[63:32], 32'h0);
      check("post edge b1", rb[63:32], 32'h0);
      check("post edge conflict", {31'b0, conf_a}, 32'h0);
      check("post edge oob", {31'b0, oob_a}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
